// File: rtl/taxi_stats_pkg.sv
// Shared types for the statistics counter scheduler: operation codes, scheduler
// state and the pipeline-stage record carried from S0 to S1.
package taxi_stats_pkg;

    // Upper bounds for the stage record; instances use the low IDX_W / CNT_W bits.
    localparam int STAT_IDX_MAX_W = 16;
    localparam int STAT_CNT_MAX_W = 128;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_INC,
        OP_RD,
        OP_RDCLR
    } stat_op_t;

    typedef enum logic {
        INIT,
        RUN
    } sched_state_t;

    typedef struct packed {
        logic                      valid;
        stat_op_t                  op;
        logic [STAT_IDX_MAX_W-1:0] index;
        logic [STAT_CNT_MAX_W-1:0] inc;
    } stat_stage_t;

endpackage

// File: rtl/taxi_axis_if.sv
// AXI4-Stream bundle used for the statistics increment stream.
interface taxi_axis_if #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = (DATA_W + 7) / 8,
    parameter int ID_W   = 8,
    parameter int USER_W = 1
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic [ID_W-1:0]   tid;
    logic [USER_W-1:0] tuser;

    modport src (output tdata, tkeep, tvalid, tid, tuser, input tready);
    modport snk (input tdata, tkeep, tvalid, tid, tuser, output tready);
endinterface

// File: rtl/taxi_stats_ram.sv
// Simple dual-port counter RAM: one write port, one synchronous read-first read port.
module taxi_stats_ram #(
    parameter int DEPTH   = 64,
    parameter int WIDTH   = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: no reset on the array so it maps to block RAM; the scheduler's INIT sweep zeroes it.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/taxi_stats_counter_sched.sv
// Statistics counter scheduler: accumulates stream increments into RAM counters and
// shares the RAM with a host read/clear port through a two-stage RMW pipeline.
module taxi_stats_counter_sched
    import taxi_stats_pkg::*;
#(
    parameter int CNT     = 64,
    parameter int CNT_W   = 64,
    parameter int ID_BASE = 0,
    parameter int ID_W    = 8,
    localparam int IDX_W  = $clog2(CNT)
) (
    input  logic             clk,
    input  logic             rst_n,
    taxi_axis_if.snk         s_axis_stat,
    input  logic             rd_req,
    input  logic [IDX_W-1:0] rd_addr,
    input  logic             rd_clear,
    output logic             rd_ack,
    output logic [CNT_W-1:0] rd_data,
    output logic             init_done
);
    localparam logic [31:0] CNT_U = CNT;

    sched_state_t     state;
    logic [IDX_W-1:0] init_idx;
    logic             rr_host_pri;
    stat_stage_t      s0, s1;
    logic             byp_hit;
    logic [CNT_W-1:0] byp_data;

    logic [ID_W-1:0]  tid_rel;
    logic             tid_in_range, run;
    logic             host_busy, host_cand, strm_cand, grant_host, grant_strm;
    logic             s1_wr, s1_host;
    logic [CNT_W-1:0] ram_rdata, cur, wr_val;

    assign run          = (state == RUN);
    assign tid_rel      = s_axis_stat.tid - ID_W'(ID_BASE);
    assign tid_in_range = 32'(tid_rel) < CNT_U;

    // A host op is in flight from its grant until its ack cycle.
    assign s1_host    = s1.valid && (s1.op inside {OP_RD, OP_RDCLR});
    assign s1_wr      = s1.valid && (s1.op inside {OP_INC, OP_RDCLR});
    assign host_busy  = s1_host || rd_ack;
    assign host_cand  = run && rd_req && !host_busy;
    assign strm_cand  = run && s_axis_stat.tvalid;
    assign grant_host = host_cand && (!strm_cand || rr_host_pri);
    assign grant_strm = strm_cand && !grant_host;

    // NOTE: tready is combinational from tvalid and the arbiter, so a beat is taken the cycle it wins.
    assign s_axis_stat.tready = grant_strm;

    always_comb begin
        s0 = '0;
        if (grant_host) begin
            s0.valid = 1'b1;
            s0.op    = rd_clear ? OP_RDCLR : OP_RD;
            s0.index = STAT_IDX_MAX_W'(rd_addr);
        end else if (grant_strm && tid_in_range) begin
            s0.valid = 1'b1;
            s0.op    = OP_INC;
            s0.index = STAT_IDX_MAX_W'(tid_rel[IDX_W-1:0]);
            s0.inc   = STAT_CNT_MAX_W'(s_axis_stat.tdata);
        end
    end

    // S1 operand: RAM is read-first, so a write to this index last cycle comes via bypass.
    assign cur    = byp_hit ? byp_data : ram_rdata;
    assign wr_val = (s1.op == OP_INC) ? CNT_W'(STAT_CNT_MAX_W'(cur) + s1.inc) : '0;

    taxi_stats_ram #(
        .DEPTH (CNT),
        .WIDTH (CNT_W)
    ) u_ram (
        .clk   (clk),
        .we    (!run || s1_wr),
        .waddr (run ? s1.index[IDX_W-1:0] : init_idx),
        .wdata (run ? wr_val : '0),
        .raddr (s0.index[IDX_W-1:0]),
        .rdata (ram_rdata)
    );

    // NOTE: all state below updates with non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT;
            init_idx    <= '0;
            init_done   <= 1'b0;
            rr_host_pri <= 1'b1;
            s1          <= '0;
            byp_hit     <= 1'b0;
            byp_data    <= '0;
            rd_ack      <= 1'b0;
            rd_data     <= '0;
        end else begin
            if (state == INIT) begin
                init_idx <= init_idx + 1'b1;
                if (init_idx == IDX_W'(CNT - 1)) begin
                    state     <= RUN;
                    init_done <= 1'b1;
                end
            end
            if (host_cand && strm_cand) rr_host_pri <= !grant_host;
            s1       <= s0;
            byp_hit  <= s0.valid && s1_wr && (s1.index == s0.index);
            byp_data <= wr_val;
            rd_ack   <= s1_host;
            if (s1_host) rd_data <= cur;
        end
    end
endmodule

// File: tb/tb_taxi_stats_counter_sched.sv
// Randomized and directed bench for taxi_stats_counter_sched against an op-ordered
// counter-array model kept in the bench.
module tb_taxi_stats_counter_sched;
    localparam int CNT     = 64;
    localparam int CNT_W   = 64;
    localparam int DATA_W  = 64;
    localparam int ID_W    = 8;
    localparam int ID_BASE = 16;
    localparam int IDX_W   = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rd_req = 1'b0;
    logic [IDX_W-1:0] rd_addr = '0;
    logic             rd_clear = 1'b0;
    logic             rd_ack;
    logic [CNT_W-1:0] rd_data;
    logic             init_done;

    taxi_axis_if #(.DATA_W(DATA_W), .ID_W(ID_W)) s_if ();

    taxi_stats_counter_sched #(
        .CNT     (CNT),
        .CNT_W   (CNT_W),
        .ID_BASE (ID_BASE),
        .ID_W    (ID_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_axis_stat (s_if),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_clear    (rd_clear),
        .rd_ack      (rd_ack),
        .rd_data     (rd_data),
        .init_done   (init_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [63:0] model [CNT];
    logic [63:0] snap  [4][CNT];
    int          req_start;
    bit          req_pend = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Model: ops take effect in grant order. A host op granted at cycle g is acked at
    // g+2, so its value is the counter state before any beat of cycle g.
    initial begin
        logic [7:0]  rel;
        logic [63:0] exp;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                foreach (model[i]) model[i] = '0;
                req_pend = 1'b0;
                continue;
            end
            if (rd_ack) begin
                exp = snap[(cyc + 2) % 4][rd_addr];
                check("rd_data_model", rd_data, exp);
                if (req_pend)
                    check("host_latency_2_to_3",
                          64'((cyc - req_start) >= 2 && (cyc - req_start) <= 3), 64'd1);
                req_pend = 1'b0;
                if (rd_clear) model[rd_addr] = model[rd_addr] - exp;
            end else if (rd_req && !req_pend) begin
                req_pend  = 1'b1;
                req_start = cyc;
            end
            snap[cyc % 4] = model;
            if (s_if.tvalid && s_if.tready) begin
                rel = s_if.tid - 8'(ID_BASE);
                if (int'(rel) < CNT) model[rel[5:0]] = model[rel[5:0]] + s_if.tdata;
            end
        end
    end

    task automatic send_beat(input logic [7:0] tid, input logic [63:0] data, input int max_stall);
        int waits;
        bit ok;
        waits = 0;
        ok    = 1'b0;
        s_if.tid    = tid;
        s_if.tdata  = data;
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (s_if.tready) begin
                ok = 1'b1;
                break;
            end
            waits++;
        end
        check("beat_accepted", 64'(ok), 64'd1);
        if (ok) check("beat_stall_bound", 64'(waits <= max_stall), 64'd1);
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic host_op(input logic [IDX_W-1:0] addr, input bit clr, input bit quiet,
                           output logic [63:0] data);
        int lat;
        bit got;
        lat  = 0;
        got  = 1'b0;
        data = 'x;
        rd_addr  = addr;
        rd_clear = clr;
        rd_req   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rd_ack) begin
                got  = 1'b1;
                data = rd_data;
                break;
            end
            lat++;
        end
        check("host_ack_seen", 64'(got), 64'd1);
        if (quiet && got) check("host_latency_quiet", 64'(lat), 64'd2);
        @(posedge clk);
        #1;
        rd_req   = 1'b0;
        rd_clear = 1'b0;
    endtask

    // Releases reset with an out-of-range beat pending and measures the INIT sweep.
    task automatic run_init();
        int  n;
        bit  seen_ready;
        n          = 0;
        seen_ready = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tid    = 8'(ID_BASE + CNT);
        s_if.tdata  = {$urandom, $urandom};
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (init_done) break;
            if (s_if.tready) seen_ready = 1'b1;
            n++;
        end
        check("init_cycles", 64'(n), 64'(CNT));
        check("init_tready_low", 64'(seen_ready), 64'd0);
        check("run_tready_high", 64'(s_if.tready), 64'd1);
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic sweep_all();
        logic [63:0] d;
        for (int a = 0; a < CNT; a++) host_op(IDX_W'(a), 1'b0, 1'b1, d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] d;
        int          acks;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tid    = '0;
        s_if.tkeep  = '1;
        s_if.tuser  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tready", 64'(s_if.tready), 64'd0);
        check("reset_rd_ack", 64'(rd_ack), 64'd0);
        check("reset_rd_data", rd_data, 64'd0);
        check("reset_init_done", 64'(init_done), 64'd0);

        run_init();
        sweep_all();

        // Back-to-back increments then an immediate read exercise the bypass path.
        send_beat(8'(ID_BASE + 3), 64'd5, 0);
        send_beat(8'(ID_BASE + 3), 64'd7, 0);
        host_op(6'd3, 1'b0, 1'b1, d);
        check("sum_idx3", d, 64'd12);

        send_beat(8'(ID_BASE + 9), 64'hFFFF_FFFF_FFFF_FFFF, 0);
        send_beat(8'(ID_BASE + 9), 64'd2, 0);
        host_op(6'd9, 1'b0, 1'b1, d);
        check("wrap_idx9", d, 64'd1);

        send_beat(8'(ID_BASE + 4), 64'd100, 0);
        fork
            host_op(6'd4, 1'b1, 1'b1, d);
            begin
                @(posedge clk);
                #1;
                send_beat(8'(ID_BASE + 4), 64'd1, 0);
            end
        join
        check("clear_read_idx4", d, 64'd100);
        host_op(6'd4, 1'b0, 1'b1, d);
        check("after_clear_idx4", d, 64'd1);

        // Contested traffic: stream never idle while the host keeps requesting.
        fork
            begin
                logic [7:0] t;
                for (int i = 0; i < 48; i++) begin
                    t = 8'(ID_BASE + $urandom_range(0, 7));
                    if ($urandom_range(0, 7) == 0) t = 8'(ID_BASE + CNT + $urandom_range(0, 50));
                    send_beat(t, {$urandom, $urandom}, 1);
                end
            end
            begin
                logic [63:0] hd;
                for (int i = 0; i < 12; i++)
                    host_op(IDX_W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0, hd);
            end
        join

        send_beat(8'(ID_BASE + CNT), 64'd55, 0);
        send_beat(8'(ID_BASE - 1), 64'd66, 0);
        sweep_all();

        // Reset while a host read sits in S1: no ack, and INIT restarts.
        @(posedge clk);
        #1;
        rd_addr = 6'd9;
        rd_req  = 1'b1;
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        rd_req = 1'b0;
        acks   = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rd_ack) acks++;
        end
        check("no_ack_after_reset", 64'(acks), 64'd0);
        run_init();
        host_op(6'd9, 1'b0, 1'b1, d);
        check("post_reset_idx9", d, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/taxi_stats_counter_sched.md
# taxi_stats_counter_sched

Statistics counter scheduler: the sink for the `m_axis_stat` increment stream produced by the MAC statistics front end. It accumulates each (index, increment) record into a RAM-resident wide counter, and shares that single counter RAM between the increment stream and a host read/clear port. The counter RAM is read-modify-written in a two-stage pipeline at one operation per cycle, with same-index bypass so back-to-back operations are exact.

## Interface
Clock `clk`; reset `rst_n`, asynchronous, active-low.

Parameters:
- `CNT`, 64: number of counters; index width `IDX_W = $clog2(CNT)`.
- `CNT_W`, 64: counter width.
- `ID_BASE`, 0: `tid` value mapping to counter 0.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `s_axis_stat`  snk  taxi_axis_if  `tdata` = increment (`DATA_W` ≤ `CNT_W`, zero-extended); `tid` = counter ID; `tkeep`/`tuser` ignored.
- `rd_req`  in  1  host operation request; held until `rd_ack`.
- `rd_addr`  in  IDX_W  counter index; stable while `rd_req` is high.
- `rd_clear`  in  1  clear the counter after reading; stable with `rd_addr`.
- `rd_ack`  out  1  single-cycle completion pulse.
- `rd_data`  out  CNT_W  counter value before any clear; valid with `rd_ack`, held until the next ack.
- `init_done`  out  1  high once the RAM zero sweep has finished.

## Operation
- States:
  - `INIT`: entered on reset release. Writes 0 to indices 0..CNT-1, one per cycle. `tready` is 0 and `rd_req` is ignored. Moves to `RUN` after index CNT-1.
  - `RUN`: normal operation.
- Stream ops: index = `tid - ID_BASE`, computed modulo 2^ID_W.
  - If index ≥ CNT, the beat is accepted and dropped, with no RAM access.
  - Otherwise counter ← counter + zero-extended `tdata`, wrapping modulo 2^CNT_W with no saturation.
- Host ops:
  - A read returns the counter value.
  - With `rd_clear`, the counter is also written back as 0.
  - An increment to the same index in the cycle after the clear sees 0.
- Arbitration in S0:
  - A candidate is `tvalid`, or `rd_req` with no host op already in flight.
  - With one candidate, it is granted.
  - With both, grant round-robin: whichever lost the last contested cycle wins.
  - `tready` = stream granted (combinational from `tvalid`/`rd_req`/RR state).
- Pipeline:
  - S0: issue RAM read address and latch op, index, increment.
  - S1: RAM data (read-first) or bypass value, then compute and write back.
  - Bypass: if the S1 write index equals the S0 read index, S1 of the next op uses the write value instead of RAM data.
- Host ack: registered from S1, so `rd_ack` is asserted the cycle after S1.

## Timing
- Reset values: `tready`=0, `rd_ack`=0, `rd_data`=0, `init_done`=0, pipeline valids 0, RR pointer → host.
- INIT lasts exactly CNT cycles. `init_done` rises on the first `RUN` cycle.
- Host latency: with `rd_req` first sampled high and granted at cycle t, `rd_ack` is asserted at t+2. Worst case under continuous stream traffic is t+3.
- Throughput: 1 op/cycle sustained. Stream stall is at most 1 cycle per host op.
- `rd_req` may deassert, or present a new request, in the cycle after `rd_ack`. A new request is not granted before `rd_ack` of the previous one.
- Increment to index k at cycle t followed by a read of k at t+1 returns the incremented value (bypass path).
- Reset asserted mid-operation: in-flight ops are discarded, no `rd_ack` is issued, and INIT re-zeroes every counter.

## Structure
- Package `taxi_stats_pkg`:
  - `stat_op_t` enum {`OP_NONE`, `OP_INC`, `OP_RD`, `OP_RDCLR`}.
  - `sched_state_t` {`INIT`, `RUN`}.
  - Pipeline-stage struct (valid, op, index, increment).
- Sub-module `taxi_stats_ram`: simple dual-port, synchronous read, read-first, parameterised depth/width, no reset. The scheduler instantiates it once.

## Test plan
- Reset release with `CNT`=64: `tready` stays 0 for 64 cycles; `init_done` rises on cycle 64; reads of all indices return 0.
- Stream `tid`=3 with `tdata`=5, then `tid`=3 with `tdata`=7, on consecutive cycles, then read index 3: `rd_data`=12, `rd_ack` 2 cycles after the request.
- Preload counter 9 to 2^64−1, stream +2 to it, then read: `rd_data`=1 (wrap).
- Read with `rd_clear` of index 4 holding 100, with +1 to index 4 streamed in the next cycle: `rd_data`=100, and a later read returns 1.
- Continuous `tvalid` plus `rd_req` every cycle: grants alternate stream/host; every beat is counted; no host request waits more than 3 cycles for its ack.
- `tid`=`ID_BASE`+CNT: beat accepted, all counters unchanged. Reset asserted with an op in S1: no `rd_ack`, and INIT restarts.
